vga_quadrant_scheduler: RTL and testbench

- Sequences the four-quadrant Genius play field onto the VGA colour outputs.
- Accepts colour commands from game logic into a small FIFO and lights one quadrant at a time for a programmed number of frames, separated by dark gaps.
- Produces registered 8-bit R/G/B for each pixel.
- Sits between the game FSM and the VGA timing generator: it consumes the timing generator's active-area coordinates and frame pulse, and drives VGA_R/G/B.

---
 rtl/vga_quadrant_scheduler.sv | 179 +++++++++++++++++
 tb/tb_vga_quadrant_scheduler.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_quadrant_scheduler.sv
// vga_quadrant_scheduler: queues colour commands and highlights one of the four
// play-field quadrants for ON_FRAMES frames, then keeps it dark for GAP_FRAMES frames.
// Optional macro QUAD_BORDER_EN draws a 4-pixel black cross between the quadrants.
module vga_quadrant_scheduler #(
  parameter int unsigned ON_FRAMES  = 30,
  parameter int unsigned GAP_FRAMES = 10,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       VGA_CLK,
  input  logic       reset,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       pix_active,
  input  logic       frame_start,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_color,
  output logic       cmd_ready,
  input  logic       flush,
  output logic       busy,
  output logic       done,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [7:0]  ON_INIT  = 8'(ON_FRAMES - 1);
  localparam logic [7:0]  GAP_INIT = 8'(GAP_FRAMES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [7:0]      frame_cnt_q, frame_cnt_d;
  logic [1:0]      active_color_q, active_color_d;
  logic            done_q, done_d;
  logic [1:0]      fifo_q [FIFO_DEPTH];
  logic [1:0]      fifo_d [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      r_q, r_d, g_q, g_d, b_q, b_d;

  logic full, empty, push, pop;

  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full && !flush;
  assign busy      = (state_q != S_IDLE) || !empty;
  assign done      = done_q;
  assign VGA_R     = r_q;
  assign VGA_G     = g_q;
  assign VGA_B     = b_q;

  // Sequencer: state moves only on frame boundaries so the picture never tears.
  always_comb begin
    state_d        = state_q;
    frame_cnt_d    = frame_cnt_q;
    active_color_d = active_color_q;
    done_d         = 1'b0;
    pop            = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
    end else if (frame_start) begin
      case (state_q)
        S_IDLE: begin
          if (!empty) begin
            pop            = 1'b1;
            active_color_d = fifo_q[rd_ptr_q];
            frame_cnt_d    = ON_INIT;
            state_d        = S_ON;
          end
        end
        S_ON: begin
          if (frame_cnt_q == '0) begin
            frame_cnt_d = GAP_INIT;
            state_d     = S_GAP;
          end else begin
            frame_cnt_d = frame_cnt_q - 8'd1;
          end
        end
        S_GAP: begin
          if (frame_cnt_q != '0) begin
            frame_cnt_d = frame_cnt_q - 8'd1;
          end else if (!empty) begin
            pop            = 1'b1;
            active_color_d = fifo_q[rd_ptr_q];
            frame_cnt_d    = ON_INIT;
            state_d        = S_ON;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Command FIFO: circular buffer; flush empties it and drops a same-cycle push.
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        fifo_d[wr_ptr_q] = cmd_color;
        wr_ptr_d         = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Pixel colour: active quadrant at full brightness, the others at a quarter.
  always_comb begin
    logic [1:0]  quad;
    logic [23:0] base;
    quad = {pix_y >= 10'd240, pix_x >= 10'd320};
    case (quad)
      2'd0:    base = 24'h00FF00;
      2'd1:    base = 24'hFF0000;
      2'd2:    base = 24'hFFFF00;
      default: base = 24'h0000FF;
    endcase
    if (!((state_q == S_ON) && (quad == active_color_q))) begin
      base = {base[23:16] >> 2, base[15:8] >> 2, base[7:0] >> 2};
    end
    if (!pix_active) begin
      base = '0;
    end
`ifdef QUAD_BORDER_EN
    if ((pix_x >= 10'd318 && pix_x <= 10'd321) || (pix_y >= 10'd238 && pix_y <= 10'd241)) begin
      base = '0;
    end
`else
`endif
    r_d = base[23:16];
    g_d = base[15:8];
    b_d = base[7:0];
  end

  // State register for sequencer, FIFO and pixel outputs.
  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      state_q        <= S_IDLE;
      frame_cnt_q    <= '0;
      active_color_q <= '0;
      done_q         <= 1'b0;
      fifo_q         <= '{default: '0};
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      r_q            <= '0;
      g_q            <= '0;
      b_q            <= '0;
    end else begin
      state_q        <= state_d;
      frame_cnt_q    <= frame_cnt_d;
      active_color_q <= active_color_d;
      done_q         <= done_d;
      fifo_q         <= fifo_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      r_q            <= r_d;
      g_q            <= g_d;
      b_q            <= b_d;
    end
  end

endmodule

// File: tb/tb_vga_quadrant_scheduler.sv
// Scoreboard bench for vga_quadrant_scheduler with ON_FRAMES=3, GAP_FRAMES=2, FIFO_DEPTH=4.
module tb_vga_quadrant_scheduler;

`ifdef QUAD_BORDER_EN
  localparam logic BORDER = 1'b1;
`else
  localparam logic BORDER = 1'b0;
`endif

  logic       VGA_CLK = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] pix_x = '0;
  logic [9:0] pix_y = '0;
  logic       pix_active = 1'b0;
  logic       frame_start = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_color = '0;
  logic       flush = 1'b0;
  logic       cmd_ready, busy, done;
  logic [7:0] VGA_R, VGA_G, VGA_B;

  vga_quadrant_scheduler #(.ON_FRAMES(3), .GAP_FRAMES(2), .FIFO_DEPTH(4)) dut (
    .VGA_CLK(VGA_CLK), .reset(reset), .pix_x(pix_x), .pix_y(pix_y),
    .pix_active(pix_active), .frame_start(frame_start), .cmd_valid(cmd_valid),
    .cmd_color(cmd_color), .cmd_ready(cmd_ready), .flush(flush), .busy(busy),
    .done(done), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  always #5 VGA_CLK = ~VGA_CLK;

  typedef struct {
    string       name;
    logic [23:0] rgb;
    logic        busy;
    logic        done;
    logic        ready;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic tb_chk = 1'b0;
  logic chk_d1 = 1'b0;
  logic [1:0] col [5];

  function automatic logic [23:0] bright(input logic [1:0] q);
    case (q)
      2'd0:    return 24'h00FF00;
      2'd1:    return 24'hFF0000;
      2'd2:    return 24'hFFFF00;
      default: return 24'h0000FF;
    endcase
  endfunction

  function automatic logic [23:0] dim(input logic [1:0] q);
    case (q)
      2'd0:    return 24'h003F00;
      2'd1:    return 24'h3F0000;
      2'd2:    return 24'h3F3F00;
      default: return 24'h00003F;
    endcase
  endfunction

  task automatic tick();
    @(posedge VGA_CLK);
    #1;
    frame_start = 1'b0;
    cmd_valid   = 1'b0;
    flush       = 1'b0;
    tb_chk      = 1'b0;
  endtask

  task automatic at_quad(input logic [1:0] q);
    pix_active = 1'b1;
    pix_x = q[0] ? 10'd480 : 10'd100;
    pix_y = q[1] ? 10'd400 : 10'd100;
  endtask

  task automatic at_xy(input logic [9:0] x, input logic [9:0] y);
    pix_active = 1'b1;
    pix_x = x;
    pix_y = y;
  endtask

  // Expectation describes the outputs after the clock edge that samples this cycle's inputs.
  task automatic expect_out(input string nm, input logic [23:0] rgb, input logic b,
                            input logic d, input logic r);
    exp_t e;
    e.name = nm; e.rgb = rgb; e.busy = b; e.done = d; e.ready = r;
    sb.push_back(e);
    tb_chk = 1'b1;
  endtask

  always @(posedge VGA_CLK) chk_d1 <= tb_chk;

  // Monitor: pops one expectation per flagged cycle and compares.
  always @(negedge VGA_CLK) begin
    exp_t e;
    logic [23:0] got;
    if (chk_d1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL sb_underflow: output flagged with no expectation queued");
      end else begin
        e   = sb.pop_front();
        got = {VGA_R, VGA_G, VGA_B};
        if (got !== e.rgb || busy !== e.busy || done !== e.done || cmd_ready !== e.ready) begin
          n_bad++;
          $display("FAIL %s: got rgb=%06h busy=%b done=%b ready=%b, expected rgb=%06h busy=%b done=%b ready=%b",
                   e.name, got, busy, done, cmd_ready, e.rgb, e.busy, e.done, e.ready);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    col[0] = 2'd0; col[1] = 2'd2; col[2] = 2'd3; col[3] = 2'd1; col[4] = 2'd2;

    // Reset and idle
    at_quad(2'd0);
    tick(); tick();
    expect_out("reset", 24'h0, 1'b0, 1'b0, 1'b1);
    tick(); reset = 1'b0;
    at_quad(2'd0); expect_out("idle_tl", 24'h003F00, 1'b0, 1'b0, 1'b1);
    tick(); at_quad(2'd3); expect_out("idle_br", 24'h00003F, 1'b0, 1'b0, 1'b1);
    tick(); pix_active = 1'b0; expect_out("blank", 24'h0, 1'b0, 1'b0, 1'b1);

    // Single red command: 3 frames bright, 2 dark, done on 5th frame_start after pop
    tick(); cmd_valid = 1'b1; cmd_color = 2'd1; at_quad(2'd1);
    expect_out("push1", 24'h3F0000, 1'b1, 1'b0, 1'b1);
    tick(); frame_start = 1'b1; at_quad(2'd1);
    expect_out("fs0", 24'h3F0000, 1'b1, 1'b0, 1'b1);
    tick(); at_quad(2'd1); expect_out("on_tr", 24'hFF0000, 1'b1, 1'b0, 1'b1);
    tick(); at_quad(2'd0); expect_out("on_tl_dim", 24'h003F00, 1'b1, 1'b0, 1'b1);
    for (int f = 1; f <= 5; f++) begin
      tick(); frame_start = 1'b1; at_quad(2'd1);
      expect_out($sformatf("fs%0d", f), (f <= 3) ? 24'hFF0000 : 24'h3F0000,
                 f < 5, f == 5, 1'b1);
      tick(); at_quad(2'd1);
      expect_out($sformatf("post_fs%0d", f), (f <= 2) ? 24'hFF0000 : 24'h3F0000,
                 f < 5, 1'b0, 1'b1);
    end

    // Fill the FIFO past its depth; fifth command waits for the first pop
    for (int i = 0; i < 5; i++) begin
      tick(); cmd_valid = 1'b1; cmd_color = col[i]; at_quad(2'd0);
      expect_out($sformatf("fill%0d", i), 24'h003F00, 1'b1, 1'b0, i < 3);
    end
    tick(); frame_start = 1'b1; cmd_valid = 1'b1; cmd_color = col[4]; at_quad(2'd0);
    expect_out("pop_full", 24'h003F00, 1'b1, 1'b0, 1'b1);
    tick(); cmd_valid = 1'b1; cmd_color = col[4]; at_quad(2'd0);
    expect_out("fifth_in", 24'h00FF00, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k < 5; k++) begin
      repeat (4) begin tick(); frame_start = 1'b1; end
      tick(); frame_start = 1'b1;
      tick(); at_quad(col[k]);
      expect_out($sformatf("order%0d", k), bright(col[k]), 1'b1, 1'b0, 1'b1);
    end
    repeat (4) begin tick(); frame_start = 1'b1; end
    tick(); frame_start = 1'b1; at_quad(2'd0);
    expect_out("seq_done", 24'h003F00, 1'b0, 1'b1, 1'b1);
    tick(); at_quad(2'd0); expect_out("after_done", 24'h003F00, 1'b0, 1'b0, 1'b1);

    // Flush during ON with two commands still queued
    tick(); cmd_valid = 1'b1; cmd_color = 2'd3;
    tick(); cmd_valid = 1'b1; cmd_color = 2'd1;
    tick(); cmd_valid = 1'b1; cmd_color = 2'd0;
    tick(); frame_start = 1'b1;
    tick(); flush = 1'b1; cmd_valid = 1'b1; cmd_color = 2'd2; at_quad(2'd3);
    expect_out("flush", 24'h0000FF, 1'b0, 1'b0, 1'b1);
    tick(); at_quad(2'd3); expect_out("post_flush", 24'h00003F, 1'b0, 1'b0, 1'b1);
    tick(); frame_start = 1'b1; at_quad(2'd3);
    expect_out("fs_after_flush", dim(2'd3), 1'b0, 1'b0, 1'b1);
    tick(); at_quad(2'd3); expect_out("still_idle", dim(2'd3), 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a gap
    tick(); cmd_valid = 1'b1; cmd_color = 2'd0;
    tick(); frame_start = 1'b1;
    repeat (3) begin tick(); frame_start = 1'b1; end
    tick(); at_quad(2'd0); expect_out("gap", 24'h003F00, 1'b1, 1'b0, 1'b1);
    tick(); reset = 1'b1; at_quad(2'd0); expect_out("rst_gap", 24'h0, 1'b0, 1'b0, 1'b1);
    tick(); reset = 1'b0; at_quad(2'd0); expect_out("post_rst", 24'h003F00, 1'b0, 1'b0, 1'b1);
    tick(); cmd_valid = 1'b1; cmd_color = 2'd2; at_quad(2'd2);
    expect_out("push_after_rst", 24'h3F3F00, 1'b1, 1'b0, 1'b1);
    tick(); frame_start = 1'b1;
    tick(); at_quad(2'd2); expect_out("restart_bl", 24'hFFFF00, 1'b1, 1'b0, 1'b1);

    // Quadrant boundary / optional border cross with green active
    tick(); flush = 1'b1;
    tick(); cmd_valid = 1'b1; cmd_color = 2'd0;
    tick(); frame_start = 1'b1;
    tick(); at_xy(10'd319, 10'd100);
    expect_out("cross_319", BORDER ? 24'h0 : 24'h00FF00, 1'b1, 1'b0, 1'b1);
    tick(); at_xy(10'd320, 10'd239);
    expect_out("cross_320_239", BORDER ? 24'h0 : 24'h3F0000, 1'b1, 1'b0, 1'b1);
    tick(); at_xy(10'd317, 10'd100);
    expect_out("edge_317", 24'h00FF00, 1'b1, 1'b0, 1'b1);
    tick(); at_xy(10'd322, 10'd242);
    expect_out("edge_322_242", 24'h00003F, 1'b1, 1'b0, 1'b1);

    tick(); tick(); tick();
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_leftover: %0d expectations never checked, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
